// File: rtl/bitonic_sort8.sv
// Eight-element unsigned byte sorter: loads 8 values serially, runs a 6-stage
// bitonic network one stage per cycle, then streams the result out ascending.
module bitonic_sort8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] number_in,
    output logic       busy,
    output logic       out_valid,
    output logic [7:0] number_out
);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_SORT = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    localparam logic [2:0] LAST_STAGE = 3'd5;
    localparam logic [2:0] LAST_SLOT  = 3'd7;

    logic [1:0] state;
    logic [2:0] cnt;
    logic [2:0] stage;
    logic [2:0] emit_idx;
    logic [7:0] data_buf  [0:7];
    logic [7:0] stage_out [0:7];

    logic [3:0] stage_k;
    logic [3:0] stage_j;
    logic [2:0] partner;

    // (k, j) schedule of the 8-input bitonic network, one entry per SORT cycle.
    always_comb begin
        case (stage)
            3'd0:    begin stage_k = 4'd2; stage_j = 4'd1; end
            3'd1:    begin stage_k = 4'd4; stage_j = 4'd2; end
            3'd2:    begin stage_k = 4'd4; stage_j = 4'd1; end
            3'd3:    begin stage_k = 4'd8; stage_j = 4'd4; end
            3'd4:    begin stage_k = 4'd8; stage_j = 4'd2; end
            default: begin stage_k = 4'd8; stage_j = 4'd1; end
        endcase
    end

    // One network stage: four parallel compare-exchanges on (i, i^j), i < i^j.
    // Equal values never swap, so ties keep their positions.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional write; a path that skips an assignment infers a latch.
        partner = '0;
        for (int i = 0; i < 8; i++) begin
            stage_out[i] = data_buf[i];
        end
        for (int i = 0; i < 8; i++) begin
            partner = 3'(i) ^ stage_j[2:0];
            if ((3'(i) & stage_j[2:0]) == 3'd0) begin
                if ((4'(i) & stage_k) == 4'd0) begin
                    if (data_buf[i] > data_buf[partner]) begin
                        stage_out[i]       = data_buf[partner];
                        stage_out[partner] = data_buf[i];
                    end
                end else begin
                    if (data_buf[i] < data_buf[partner]) begin
                        stage_out[i]       = data_buf[partner];
                        stage_out[partner] = data_buf[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register in this block samples pre-edge values, like real flops.
        if (!rst_n) begin
            state      <= ST_LOAD;
            cnt        <= '0;
            stage      <= '0;
            emit_idx   <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            number_out <= '0;
            // NOTE: the element buffer is only 8 bytes of flops, so it is
            // cleared on reset; larger RAM-style storage would not be.
            for (int i = 0; i < 8; i++) begin
                data_buf[i] <= '0;
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        data_buf[cnt] <= number_in;
                        if (cnt == LAST_SLOT) begin
                            cnt   <= '0;
                            stage <= '0;
                            busy  <= 1'b1;
                            state <= ST_SORT;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end

                ST_SORT: begin
                    for (int i = 0; i < 8; i++) begin
                        data_buf[i] <= stage_out[i];
                    end
                    if (stage == LAST_STAGE) begin
                        stage    <= '0;
                        emit_idx <= '0;
                        state    <= ST_EMIT;
                    end else begin
                        stage <= stage + 3'd1;
                    end
                end

                ST_EMIT: begin
                    // emit_idx wraps to 0 after the 8th element; out_valid
                    // separates that wrap from the entry into EMIT.
                    if (out_valid && emit_idx == 3'd0) begin
                        out_valid  <= 1'b0;
                        busy       <= 1'b0;
                        number_out <= '0;
                        state      <= ST_LOAD;
                    end else begin
                        out_valid  <= 1'b1;
                        number_out <= data_buf[emit_idx];
                        emit_idx   <= emit_idx + 3'd1;
                    end
                end

                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitonic_sort8.sv
// Directed bench for bitonic_sort8: hand-sorted batches, output timing,
// busy window, input masking while busy, mid-emit reset and back-to-back loads.
module tb_bitonic_sort8;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] number_in;
    logic       busy;
    logic       out_valid;
    logic [7:0] number_out;

    int vectors;
    int miscompares;

    bitonic_sort8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .number_in  (number_in),
        .busy       (busy),
        .out_valid  (out_valid),
        .number_out (number_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All driving and sampling happens 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives 8 elements with `gap` idle cycles between them; returns just after
    // the edge that captured the 8th one. With hold set, in_valid stays high.
    task automatic load8(input logic [7:0] v [8], input int gap, input bit hold);
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            number_in = v[i];
            step();
            if (i < 7 && gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) step();
            end
        end
        if (!hold) in_valid = 1'b0;
    endtask

    // Called right after the capture edge. Edge numbers count from it (edge 1
    // is the next one). Stops the edge busy falls, or after 40 edges.
    task automatic collect(input bit churn, output logic [7:0] got [8],
                           output int n, output int first_e, output int last_e,
                           output int busy_edges, output bit ended);
        logic was_busy;
        n = 0; first_e = -1; last_e = -1; busy_edges = 0; ended = 1'b0;
        for (int k = 0; k < 8; k++) got[k] = '0;
        for (int e = 1; e <= 40 && !ended; e++) begin
            was_busy = busy;
            if (churn) number_in = number_in + 8'd37;
            step();
            if (was_busy && busy) busy_edges++;
            if (out_valid) begin
                if (n < 8) got[n] = number_out;
                if (n == 0) first_e = e;
                last_e = e;
                n++;
            end
            if (was_busy && !busy) ended = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        number_in = 8'hEE;
        repeat (3) step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (number_out !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_number_out: got %0d expected 0", number_out);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
    endtask

    task automatic test_descending();
        logic [7:0] stim [8];
        logic [7:0] expd [8];
        logic [7:0] got [8];
        int n, first_e, last_e, bedges;
        bit ended;
        stim = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        expd = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load8(stim, 0, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL desc_busy_on_capture: got %b expected 1", busy);
        end
        collect(1'b0, got, n, first_e, last_e, bedges, ended);
        vectors++;
        if (!ended || n !== 8) begin
            miscompares++;
            $display("FAIL desc_count: got %0d outputs (ended=%0d) expected 8", n, ended);
        end
        vectors++;
        if (first_e !== 7 || last_e !== 14) begin
            miscompares++;
            $display("FAIL desc_timing: got edges %0d..%0d expected 7..14", first_e, last_e);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got[i] !== expd[i]) begin
                miscompares++;
                $display("FAIL desc_out[%0d]: got %0d expected %0d", i, got[i], expd[i]);
            end
        end
        vectors++;
        if (out_valid !== 1'b0 || number_out !== 8'd0) begin
            miscompares++;
            $display("FAIL desc_return: got out_valid=%b number_out=%0d expected 0/0",
                     out_valid, number_out);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] stim [8];
        logic [7:0] expd [8];
        logic [7:0] got [8];
        int n, first_e, last_e, bedges;
        bit ended;
        stim = '{8'd200, 8'd3, 8'd3, 8'd255, 8'd0, 8'd17, 8'd3, 8'd128};
        expd = '{8'd0, 8'd3, 8'd3, 8'd3, 8'd17, 8'd128, 8'd200, 8'd255};
        load8(stim, 2, 1'b0);
        collect(1'b0, got, n, first_e, last_e, bedges, ended);
        vectors++;
        if (!ended || n !== 8 || first_e !== 7) begin
            miscompares++;
            $display("FAIL gaps_shape: got n=%0d first=%0d ended=%0d expected 8/7/1",
                     n, first_e, ended);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got[i] !== expd[i]) begin
                miscompares++;
                $display("FAIL gaps_out[%0d]: got %0d expected %0d", i, got[i], expd[i]);
            end
        end
    endtask

    task automatic test_all_equal();
        logic [7:0] stim [8];
        logic [7:0] got [8];
        int n, first_e, last_e, bedges;
        bit ended;
        for (int i = 0; i < 8; i++) stim[i] = 8'h5A;
        load8(stim, 0, 1'b0);
        collect(1'b0, got, n, first_e, last_e, bedges, ended);
        // busy rises on the capture edge, falls on edge 15: held across edges 1..14.
        vectors++;
        if (!ended || bedges !== 14) begin
            miscompares++;
            $display("FAIL equal_busy_cycles: got %0d expected 14", bedges);
        end
        vectors++;
        if (n !== 8) begin
            miscompares++;
            $display("FAIL equal_count: got %0d expected 8", n);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got[i] !== 8'h5A) begin
                miscompares++;
                $display("FAIL equal_out[%0d]: got %0h expected 5a", i, got[i]);
            end
        end
    endtask

    task automatic test_ignore_while_busy();
        logic [7:0] stim [8];
        logic [7:0] expd [8];
        logic [7:0] nxt  [8];
        logic [7:0] nexp [8];
        logic [7:0] got [8];
        int n, first_e, last_e, bedges;
        bit ended;
        stim = '{8'd40, 8'd90, 8'd10, 8'd70, 8'd30, 8'd80, 8'd20, 8'd60};
        expd = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd60, 8'd70, 8'd80, 8'd90};
        nxt  = '{8'd5, 8'd250, 8'd6, 8'd249, 8'd7, 8'd248, 8'd8, 8'd247};
        nexp = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd247, 8'd248, 8'd249, 8'd250};
        load8(stim, 0, 1'b1);
        collect(1'b1, got, n, first_e, last_e, bedges, ended);
        in_valid = 1'b0;
        vectors++;
        if (!ended || n !== 8) begin
            miscompares++;
            $display("FAIL hold_count: got %0d expected 8", n);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got[i] !== expd[i]) begin
                miscompares++;
                $display("FAIL hold_out[%0d]: got %0d expected %0d", i, got[i], expd[i]);
            end
        end
        // A fresh batch sorting with nominal timing shows cnt restarted at 0.
        load8(nxt, 0, 1'b0);
        collect(1'b0, got, n, first_e, last_e, bedges, ended);
        vectors++;
        if (first_e !== 7 || n !== 8) begin
            miscompares++;
            $display("FAIL hold_next_timing: got first=%0d n=%0d expected 7/8", first_e, n);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got[i] !== nexp[i]) begin
                miscompares++;
                $display("FAIL hold_next_out[%0d]: got %0d expected %0d", i, got[i], nexp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        logic [7:0] stim [8];
        logic [7:0] shuf [8];
        logic [7:0] got [8];
        int n, first_e, last_e, bedges, seen, stale;
        bit ended;
        stim = '{8'd99, 8'd11, 8'd55, 8'd33, 8'd77, 8'd22, 8'd88, 8'd44};
        shuf = '{8'd5, 8'd2, 8'd8, 8'd1, 8'd7, 8'd3, 8'd6, 8'd4};
        load8(stim, 0, 1'b0);
        seen = 0;
        for (int e = 0; e < 30 && seen < 3; e++) begin
            step();
            if (out_valid) seen++;
        end
        vectors++;
        if (seen !== 3) begin
            miscompares++;
            $display("FAIL rst_mid_reach_emit: got %0d outputs expected 3", seen);
        end
        rst_n = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || number_out !== 8'd0) begin
            miscompares++;
            $display("FAIL rst_mid_drop: got ov=%b busy=%b out=%0d expected 0/0/0",
                     out_valid, busy, number_out);
        end
        rst_n = 1'b1;
        stale = 0;
        repeat (20) begin
            step();
            if (out_valid || busy) stale++;
        end
        vectors++;
        if (stale !== 0) begin
            miscompares++;
            $display("FAIL rst_mid_stale: got %0d active cycles expected 0", stale);
        end
        load8(shuf, 0, 1'b0);
        collect(1'b0, got, n, first_e, last_e, bedges, ended);
        vectors++;
        if (n !== 8) begin
            miscompares++;
            $display("FAIL rst_mid_count: got %0d expected 8", n);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got[i] !== 8'(i + 1)) begin
                miscompares++;
                $display("FAIL rst_mid_out[%0d]: got %0d expected %0d", i, got[i], i + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a [8];
        logic [7:0] aexp [8];
        logic [7:0] b [8];
        logic [7:0] bexp [8];
        logic [7:0] got_a [8];
        logic [7:0] got_b [8];
        int na, nb, first_e, last_e, bedges;
        bit ended;
        a    = '{8'd13, 8'd254, 8'd0, 8'd127, 8'd128, 8'd1, 8'd64, 8'd200};
        aexp = '{8'd0, 8'd1, 8'd13, 8'd64, 8'd127, 8'd128, 8'd200, 8'd254};
        b    = '{8'd9, 8'd9, 8'd250, 8'd4, 8'd100, 8'd4, 8'd31, 8'd255};
        bexp = '{8'd4, 8'd4, 8'd9, 8'd9, 8'd31, 8'd100, 8'd250, 8'd255};
        load8(a, 0, 1'b0);
        collect(1'b0, got_a, na, first_e, last_e, bedges, ended);
        // collect returns just after the edge that drops busy: load B at once.
        load8(b, 0, 1'b0);
        collect(1'b0, got_b, nb, first_e, last_e, bedges, ended);
        vectors++;
        if (na !== 8 || nb !== 8 || first_e !== 7) begin
            miscompares++;
            $display("FAIL b2b_counts: got a=%0d b=%0d firstB=%0d expected 8/8/7",
                     na, nb, first_e);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got_a[i] !== aexp[i] || got_b[i] !== bexp[i]) begin
                miscompares++;
                $display("FAIL b2b_out[%0d]: got %0d/%0d expected %0d/%0d",
                         i, got_a[i], got_b[i], aexp[i], bexp[i]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        number_in   = '0;
        test_reset();
        test_descending();
        test_gaps();
        test_all_equal();
        test_ignore_while_busy();
        test_reset_mid_emit();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute bound so the bench always ends even if a task misbehaves.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
